key_run_ctrl: RTL

- Upstream stage of the 4-bit display counter. Turns two raw active-low board pushbuttons into clean press events.
- Gates the slow tick from the clock divider into a one-cycle count enable.
- Modes: free-run, pause and single-step. The counter advances only when count_en is high.
- Everything runs in the 50 MHz domain.

---
 rtl/key_run_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/key_run_ctrl.sv
// Run/pause/single-step control for the display counter: synchronizes and
// debounces two active-low pushbuttons, then gates the slow tick into count_en.
module key_run_ctrl #(
  parameter int unsigned         DB_WIDTH       = 20,
  parameter logic [DB_WIDTH-1:0] DEBOUNCE_COUNT = DB_WIDTH'(999_999)
) (
  input  logic clock50M,
  input  logic reset,
  input  logic key_run_n,
  input  logic key_step_n,
  input  logic tick,
  output logic count_en,
  output logic running,
  output logic step_pending
);

  typedef enum logic [1:0] {
    PAUSED    = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2
  } state_t;

  localparam int KEY_RUN  = 0;
  localparam int KEY_STEP = 1;

  logic [1:0]          keys_n;
  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0]          db;
  logic [1:0]          db_d;
  logic [1:0]          press;
  logic [DB_WIDTH-1:0] db_cnt [2];
  state_t              state;

  assign keys_n = {key_step_n, key_run_n};

  // Per key: two-flop synchronizer, saturating-window debounce, falling-edge press pulse.
  always_ff @(posedge clock50M) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '1;
      db_d  <= '1;
      press <= '0;
      // NOTE: these counters form a tiny register array, not a RAM, so they are reset explicitly.
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      sync1 <= keys_n;
      sync2 <= sync1;
      db_d  <= db;
      press <= db_d & ~db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEBOUNCE_COUNT) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_WIDTH'(1);
        end
      end
    end
  end

  // Mode FSM; running/step_pending are registered alongside the state so they never glitch.
  always_ff @(posedge clock50M) begin
    if (reset) begin
      state        <= PAUSED;
      count_en     <= 1'b0;
      running      <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      count_en <= tick && (state == RUN || state == STEP_WAIT);
      case (state)
        PAUSED: begin
          if (press[KEY_RUN]) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (press[KEY_STEP]) begin
            state        <= STEP_WAIT;
            step_pending <= 1'b1;
          end
        end
        RUN: begin
          if (press[KEY_RUN]) begin
            state   <= PAUSED;
            running <= 1'b0;
          end
        end
        STEP_WAIT: begin
          // A run press absorbs the pending step; otherwise the next tick consumes it.
          if (press[KEY_RUN]) begin
            state        <= RUN;
            running      <= 1'b1;
            step_pending <= 1'b0;
          end else if (tick) begin
            state        <= PAUSED;
            step_pending <= 1'b0;
          end
        end
        default: begin
          state        <= PAUSED;
          running      <= 1'b0;
          step_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule
